// File: rtl/vec_serializer_pkg.sv
// vec_serializer_pkg: shared vector-math types and default geometry
package vec_serializer_pkg;
    localparam int D_BITS_DEF   = 32;
    localparam int VEC_LEN_DEF  = 3;
    localparam int CNT_BITS_DEF = 16;
    typedef logic [VEC_LEN_DEF-1:0][D_BITS_DEF-1:0] vec_t;
    typedef enum logic {S_IDLE, S_SEND} state_t;
endpackage

// File: rtl/vec_serializer.sv
// vec_serializer: pops one vector from an FWFT FIFO and writes its lanes, lane 0 first, to a scalar FIFO
module vec_serializer
    import vec_serializer_pkg::*;
#(
    parameter int D_BITS   = D_BITS_DEF,
    parameter int VEC_LEN  = VEC_LEN_DEF,
    parameter int CNT_BITS = CNT_BITS_DEF
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [D_BITS*VEC_LEN-1:0] in_dout,
    input  logic                      in_empty,
    output logic                      in_rd_en,
    output logic [D_BITS-1:0]         out_din,
    output logic                      out_last,
    input  logic                      out_full,
    output logic                      out_wr_en,
    output logic [CNT_BITS-1:0]       vec_count
);
    localparam int IW = $clog2(VEC_LEN);
    localparam logic [IW-1:0] LAST = IW'(VEC_LEN - 1);

    state_t                          state, state_n;
    logic [IW-1:0]                   idx;
    logic [VEC_LEN-1:0][D_BITS-1:0]  hold;
    logic                            last;

    always_comb begin
        last      = idx == LAST;
        out_wr_en = !reset && state == S_SEND && !out_full;
        // a pop may share the cycle with the final lane write, giving back-to-back vectors
        in_rd_en  = !reset && !in_empty && (state == S_IDLE || (out_wr_en && last));
        out_din   = state == S_SEND ? hold[idx] : '0;
        out_last  = state == S_SEND && last;
        state_n   = in_rd_en ? S_SEND : (out_wr_en && last) ? S_IDLE : state;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            hold      <= '0;
            vec_count <= '0;
        end else begin
            state <= state_n;
            if (in_rd_en) begin
                hold <= in_dout;
                idx  <= '0;
            end else if (out_wr_en) begin
                idx <= idx + IW'(1);
            end
            if (out_wr_en && last)
                vec_count <= vec_count + CNT_BITS'(1);
        end
    end
endmodule
